square_wave_fourier_gen: RTL and testbench
==========================================

Name: square_wave_fourier_gen

Overview:
Free-running digital synthesiser that outputs a square-wave approximation built from a truncated Fourier series, Σ (4/π)·sin(k·θ)/k over the odd harmonics k = 1, 3, 5, 7.
- A phase accumulator sets the output frequency.
- Each harmonic is read from a shared sine ROM, weighted, summed, biased and saturated to an unsigned 8-bit sample.
- The sample feeds a DAC or PWM stage, or is dumped for waveform inspection.

Parameters:
- PHASE_W, 16, phase accumulator width (bits).
- PHASE_STEP, 256, per-cycle phase increment (tuning word); f_out = f_clk·PHASE_STEP/2^PHASE_W.
- OUT_W, 8, output sample width (unsigned).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- wave_out  output  OUT_W  unsigned offset-binary sample; 128 = zero level.

Behaviour:
- Reset (rst=0, asynchronous): phase=0, all pipeline registers=0, wave_out=128. Registers stay in reset while rst is low. Deassertion is sampled at the next clk edge.
- Phase: phase ← phase + PHASE_STEP each cycle, modulo 2^PHASE_W. Wrap-around is silent.
- Harmonic phases: φk = (k·phase) mod 2^PHASE_W for k ∈ {1,3,5,7}. Use constant multiplies and truncate to PHASE_W bits.
- Sine ROM: 256 entries, signed 8-bit, sin_lut[i] = round(127·sin(2πi/256)). It is indexed by φk[PHASE_W-1:PHASE_W-8]. Anchor values: idx 0=0, 64=127, 128=0, 192=−127.
- Weights: unsigned constants ck = round(256·4/(π·k)), giving c1=326, c3=109, c5=65, c7=47.
- Sum S = Σ sin_k·ck, held in a signed accumulator of at least 18 bits; no overflow is possible.
- Output: y = (S >>> 8) + 128, using an arithmetic shift (floor). Saturate y to [0,255] and assign it to wave_out.
- Pipeline, one register per stage:
  - Stage 1: registered ROM outputs for the current phase.
  - Stage 2: registered weighted sum S.
  - Stage 3: registered wave_out.
- Latency is 3 cycles from the phase value to wave_out. Throughput is one sample per cycle.
- First cycles after reset: wave_out=128 until the pipeline fills. Phase 0 also yields 128, so no glitch appears.
- Gibbs overshoot near edges can exceed the range. Saturation clamps it; results never wrap.
- PHASE_STEP=0 is legal: the output is a constant 128.
- PHASE_STEP ≥ 2^(PHASE_W−1) is legal and aliases; no special handling.
- Reset mid-operation: immediate return to the reset values. The sequence restarts from phase 0.

Decomposition:
- Package fourier_pkg holds:
  - LUT_DEPTH=256, LUT_AW=8, SIN_AMP=127.
  - The harmonic list {1,3,5,7} and weight constants {326,109,65,47}.
  - SUM_W=18 and OUT_BIAS=128.
- Sub-module sine_lut_256 is a combinational or registered ROM (addr 8b → signed 8b) instantiated four times, one per harmonic. It may be replaced by a single quarter-wave ROM plus symmetry logic, with identical outputs.

Test Plan:
- Reset hold: rst=0 for 5 cycles with clk running → wave_out=128 throughout; release → wave_out stays 128 for 3 cycles.
- Quarter phase: PHASE_STEP=256, phase reaches 0x4000 (cycle 64 after release) → 3 cycles later wave_out=244. Check S=127·(326−109+65−47)=29845.
- Three-quarter phase: phase=0xC000 → S=−29845, wave_out=11 (floor of −116.58 is −117, plus 128).
- Periodicity/wrap: PHASE_STEP=256 → wave_out repeats exactly every 256 cycles across phase wrap. PHASE_STEP=512 → every 128 cycles. PHASE_STEP=64 → every 1024 cycles.
- Saturation: run a full period at PHASE_STEP=64 → wave_out never wraps (no 255→0 or 0→255 jumps) and peak samples clamp at 255/0 where the computed y goes out of range.
- Async reset mid-run: drop rst between clk edges at an arbitrary phase → wave_out=128 immediately without waiting for a clk edge. After release the output sequence matches the post-reset sequence from the first test.

Source files
------------

// File: rtl/fourier_pkg.sv
// Shared constants for the truncated-Fourier square-wave synthesiser:
// sine ROM geometry, harmonic numbers, weights and the quarter-wave table.
package fourier_pkg;

  localparam int LUT_DEPTH = 256;
  localparam int LUT_AW    = 8;
  localparam int SIN_AMP   = 127;
  localparam int NUM_HARM  = 4;
  localparam int SUM_W     = 18;
  localparam int OUT_BIAS  = 128;

  // Odd harmonics and their weights round(256*4/(pi*k)).
  localparam int HARM_K [NUM_HARM] = '{1, 3, 5, 7};
  localparam int HARM_C [NUM_HARM] = '{326, 109, 65, 47};

  // First quadrant (inclusive of 90 degrees) of round(127*sin(2*pi*i/256)).
  function automatic logic [6:0] quarter_sine(input logic [6:0] idx);
    logic [6:0] mag;
    case (idx)
      7'd0:  mag = 7'd0;    7'd1:  mag = 7'd3;    7'd2:  mag = 7'd6;    7'd3:  mag = 7'd9;
      7'd4:  mag = 7'd12;   7'd5:  mag = 7'd16;   7'd6:  mag = 7'd19;   7'd7:  mag = 7'd22;
      7'd8:  mag = 7'd25;   7'd9:  mag = 7'd28;   7'd10: mag = 7'd31;   7'd11: mag = 7'd34;
      7'd12: mag = 7'd37;   7'd13: mag = 7'd40;   7'd14: mag = 7'd43;   7'd15: mag = 7'd46;
      7'd16: mag = 7'd49;   7'd17: mag = 7'd51;   7'd18: mag = 7'd54;   7'd19: mag = 7'd57;
      7'd20: mag = 7'd60;   7'd21: mag = 7'd63;   7'd22: mag = 7'd65;   7'd23: mag = 7'd68;
      7'd24: mag = 7'd71;   7'd25: mag = 7'd73;   7'd26: mag = 7'd76;   7'd27: mag = 7'd78;
      7'd28: mag = 7'd81;   7'd29: mag = 7'd83;   7'd30: mag = 7'd85;   7'd31: mag = 7'd88;
      7'd32: mag = 7'd90;   7'd33: mag = 7'd92;   7'd34: mag = 7'd94;   7'd35: mag = 7'd96;
      7'd36: mag = 7'd98;   7'd37: mag = 7'd100;  7'd38: mag = 7'd102;  7'd39: mag = 7'd104;
      7'd40: mag = 7'd106;  7'd41: mag = 7'd107;  7'd42: mag = 7'd109;  7'd43: mag = 7'd111;
      7'd44: mag = 7'd112;  7'd45: mag = 7'd113;  7'd46: mag = 7'd115;  7'd47: mag = 7'd116;
      7'd48: mag = 7'd117;  7'd49: mag = 7'd118;  7'd50: mag = 7'd120;  7'd51: mag = 7'd121;
      7'd52: mag = 7'd122;  7'd53: mag = 7'd122;  7'd54: mag = 7'd123;  7'd55: mag = 7'd124;
      7'd56: mag = 7'd125;  7'd57: mag = 7'd125;  7'd58: mag = 7'd126;  7'd59: mag = 7'd126;
      7'd60: mag = 7'd126;  7'd61: mag = 7'd127;  7'd62: mag = 7'd127;  7'd63: mag = 7'd127;
      7'd64: mag = 7'd127;
      default: mag = 7'd0;
    endcase
    return mag;
  endfunction

endpackage

// File: rtl/sine_lut_256.sv
// 256-entry signed sine ROM built from a quarter-wave table plus symmetry.
module sine_lut_256
  import fourier_pkg::*;
(
  input  logic [LUT_AW-1:0] addr,
  output logic signed [7:0] data
);

  logic [6:0] offset;
  logic [7:0] mirror;
  logic [6:0] qidx;
  logic [6:0] mag;

  // Fold the address into the first quadrant, then restore the sign for the lower half.
  always_comb begin
    offset = addr[6:0];
    mirror = 8'd128 - {1'b0, offset};
    if (offset <= 7'd64) begin
      qidx = offset;
    end else begin
      qidx = mirror[6:0];
    end
    mag = quarter_sine(qidx);
    if (addr[7]) begin
      data = 8'sd0 - $signed({1'b0, mag});
    end else begin
      data = $signed({1'b0, mag});
    end
  end

endmodule

// File: rtl/square_wave_fourier_gen.sv
// Square-wave synthesiser: phase accumulator, four harmonic ROM lookups,
// weighted sum, bias and saturation, in a three-stage pipeline.
module square_wave_fourier_gen
  import fourier_pkg::*;
#(
  parameter int PHASE_W    = 16,
  parameter int PHASE_STEP = 256,
  parameter int OUT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] wave_out
);

  logic [PHASE_W-1:0]      phase;
  logic [LUT_AW-1:0]       lut_addr [NUM_HARM];
  logic signed [7:0]       lut_data [NUM_HARM];
  logic signed [7:0]       sin_q    [NUM_HARM];
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] y_raw;
  logic [OUT_W-1:0]        y_sat;

  // Harmonic phase k*phase truncated to PHASE_W bits; ROM index is its top byte.
  genvar g;
  for (g = 0; g < NUM_HARM; g++) begin : g_harm
    assign lut_addr[g] = LUT_AW'((phase * PHASE_W'(HARM_K[g])) >> (PHASE_W - LUT_AW));
    sine_lut_256 u_lut (
      .addr (lut_addr[g]),
      .data (lut_data[g])
    );
  end

  // Free-running phase accumulator; wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_W'(PHASE_STEP);
    end
  end

  // Stage 1: capture the four ROM outputs for the current phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NUM_HARM; j++) sin_q[j] <= 8'sd0;
    end else begin
      for (int j = 0; j < NUM_HARM; j++) sin_q[j] <= lut_data[j];
    end
  end

  // Weighted sum of harmonics; the worst case magnitude fits in SUM_W bits.
  always_comb begin
    sum_next = '0;
    for (int j = 0; j < NUM_HARM; j++) begin
      sum_next = sum_next + SUM_W'(sin_q[j]) * $signed(SUM_W'(HARM_C[j]));
    end
  end

  // Stage 2: register the sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_next;
    end
  end

  // Floor-divide by 256, add the mid-scale bias and clamp to the output range.
  always_comb begin
    y_raw = (sum_q >>> 8) + $signed(SUM_W'(OUT_BIAS));
    if (y_raw < $signed(SUM_W'(0))) begin
      y_sat = '0;
    end else if (y_raw > $signed(SUM_W'((1 << OUT_W) - 1))) begin
      y_sat = '1;
    end else begin
      y_sat = y_raw[OUT_W-1:0];
    end
  end

  // Stage 3: registered output sample; rests at mid-scale in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wave_out <= OUT_W'(OUT_BIAS);
    end else begin
      wave_out <= y_sat;
    end
  end

endmodule

// File: tb/tb_square_wave_fourier_gen.sv
// Scoreboard bench: four instances with different tuning words are checked
// every cycle against a floating-point Fourier-series reference model,
// across randomly timed asynchronous resets.
module tb_square_wave_fourier_gen;

  localparam int ND = 4;
  localparam int STEPS [ND] = '{256, 512, 64, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wave [ND];

  int checks = 0;
  int errors = 0;
  int k = 0;                 // clock edges since reset release
  logic [7:0] sb [ND][$];    // expected samples per instance

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    square_wave_fourier_gen #(
      .PHASE_W    (16),
      .PHASE_STEP (STEPS[g]),
      .OUT_W      (8)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .wave_out (wave[g])
    );
  end

  // round(127*sin(2*pi*idx/256))
  function automatic int sine_ref(input int idx);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * idx / 256.0);
    return $rtoi($floor(x + 0.5));
  endfunction

  // Sample for a given accumulator phase, straight from the series definition.
  function automatic int model(input int ph);
    int hk [4];
    int ck [4];
    int s;
    int y;
    hk = '{1, 3, 5, 7};
    ck = '{326, 109, 65, 47};
    s = 0;
    for (int j = 0; j < 4; j++) begin
      s = s + sine_ref(((hk[j] * ph) % 65536) / 256) * ck[j];
    end
    y = $rtoi($floor(real'(s) / 256.0)) + 128;
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    return y;
  endfunction

  // Output after n edges reflects the phase held three edges earlier.
  function automatic int expected(input int n, input int step);
    if (n < 3) return 128;
    return model(((n - 3) * step) % 65536);
  endfunction

  // Stimulus side: push the expected sample for every instance at each edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) k = 0;
      else k = k + 1;
      for (int d = 0; d < ND; d++) begin
        if (!rst) sb[d].push_back(8'd128);
        else sb[d].push_back(8'(expected(k, STEPS[d])));
      end
    end
  end

  // Monitor side: compare on the falling edge, away from the update edge.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks = checks + 1;
        if (sb[d].size() == 0) begin
          errors = errors + 1;
          $display("FAIL scoreboard_empty dut%0d got=%0d", d, wave[d]);
        end else begin
          exp_v = sb[d].pop_front();
          if (wave[d] !== exp_v) begin
            errors = errors + 1;
            $display("FAIL sample dut%0d step=%0d k=%0d got=%0d exp=%0d",
                     d, STEPS[d], k, wave[d], exp_v);
          end
        end
      end
      if (rst && k == 67) begin
        checks = checks + 1;
        if (wave[0] !== 8'd244) begin
          errors = errors + 1;
          $display("FAIL quarter_phase got=%0d exp=244", wave[0]);
        end
      end
      if (rst && k == 195) begin
        checks = checks + 1;
        if (wave[0] !== 8'd11) begin
          errors = errors + 1;
          $display("FAIL three_quarter_phase got=%0d exp=11", wave[0]);
        end
      end
    end
  end

  // Main sequence: reset hold, long run, then randomly placed async resets.
  initial begin
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #7 rst = 1'b1;
    repeat (1100) @(posedge clk);
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(400, 50)) @(posedge clk);
      #($urandom_range(8, 6));
      rst = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
        checks = checks + 1;
        if (wave[d] !== 8'd128) begin
          errors = errors + 1;
          $display("FAIL async_reset dut%0d got=%0d exp=128", d, wave[d]);
        end
      end
      repeat ($urandom_range(4, 1)) @(posedge clk);
      #7 rst = 1'b1;
    end
    repeat (300) @(posedge clk);
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
